// File: rtl/condlogic.sv
// Conditional-execution unit for a multicycle ARM-style core.
// Evaluates the condition field against the architectural flags, gates the
// register, memory and PC write strobes by the registered pass bit, updates
// the N,Z and C,V flag groups independently, and counts annulled commits.
module condlogic (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        NextPC,
  input  logic        RegW,
  input  logic        MemW,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  Flags,
  output logic        CondExD,
  output logic [15:0] AnnulCount
);

  logic       condex;
  logic [1:0] flagwrite;
  logic       condexd_reg;
  logic [15:0] annul_reg;
  logic       commit;
  logic       n_flag, z_flag, c_flag, v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = Flags;

  // Condition check uses the flags held before this edge, never ALUFlags,
  // so a flag update in the same cycle only matters from the next cycle.
  always_comb begin
    condex = 1'b0;
    case (Cond)
      4'b0000: condex = z_flag;
      4'b0001: condex = ~z_flag;
      4'b0010: condex = c_flag;
      4'b0011: condex = ~c_flag;
      4'b0100: condex = n_flag;
      4'b0101: condex = ~n_flag;
      4'b0110: condex = v_flag;
      4'b0111: condex = ~v_flag;
      4'b1000: condex = c_flag & ~z_flag;
      4'b1001: condex = ~c_flag | z_flag;
      4'b1010: condex = (n_flag == v_flag);
      4'b1011: condex = (n_flag != v_flag);
      4'b1100: condex = ~z_flag & (n_flag == v_flag);
      4'b1101: condex = z_flag | (n_flag != v_flag);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;  // reserved encoding always annuls
    endcase
  end

  assign flagwrite = FlagW & {condex, condex};

  // Bit 1 guards N,Z (Flags[3:2]); bit 0 guards C,V (Flags[1:0]).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag_grp
      logic [1:0] grp_reg;
      // Each flag group loads under its own strobe and otherwise holds.
      always_ff @(posedge clk) begin
        if (!reset)
          grp_reg <= 2'b00;
        else if (flagwrite[gi])
          grp_reg <= ALUFlags[2*gi+1 -: 2];
      end
      assign Flags[2*gi+1 -: 2] = grp_reg;
    end
  endgenerate

  // Pass bit is delayed one cycle so it lines up with the writeback stage;
  // reset clears it so no stale pass survives into the release cycle.
  always_ff @(posedge clk) begin
    if (!reset)
      condexd_reg <= 1'b0;
    else
      condexd_reg <= condex;
  end

  assign CondExD  = condexd_reg;
  assign RegWrite = RegW & condexd_reg;
  assign MemWrite = MemW & condexd_reg;
  assign PCWrite  = (PCS & condexd_reg) | NextPC;

  // Any writeback request counts as a single commit, even if several are set.
  assign commit = RegW | PCS | MemW;

  // Count commits that were annulled by a failed condition, saturating at max.
  always_ff @(posedge clk) begin
    if (!reset)
      annul_reg <= 16'h0000;
    else if (commit && !condexd_reg && (annul_reg != 16'hFFFF))
      annul_reg <= annul_reg + 16'd1;
  end

  assign AnnulCount = annul_reg;

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: directed scenarios plus random traffic,
// all compared against a flag/condition reference model kept in the bench.
module tb_condlogic;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS;
  logic        NextPC;
  logic        RegW;
  logic        MemW;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [3:0]  Flags;
  logic        CondExD;
  logic [15:0] AnnulCount;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_flags;
  bit         m_condexd;
  int         m_annul;

  always #5 clk = ~clk;

  condlogic dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Flags      (Flags),
    .CondExD    (CondExD),
    .AnnulCount (AnnulCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Condition codes come in pairs: the odd member is the negation of the
  // even one, and the last pair (AL / reserved) is "true" / "false".
  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic npc,
                       input logic rw, input logic mw);
    reset = rst; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
  endtask

  // Wait to mid-cycle and compare every output against the model.
  task automatic settle();
    @(negedge clk);
    check("flags",    32'(Flags),      32'(m_flags));
    check("condexd",  32'(CondExD),    32'(m_condexd));
    check("annul",    32'(AnnulCount), 32'(m_annul));
    check("regwrite", 32'(RegWrite),   32'(RegW && m_condexd));
    check("memwrite", 32'(MemWrite),   32'(MemW && m_condexd));
    check("pcwrite",  32'(PCWrite),    32'((PCS && m_condexd) || NextPC));
  endtask

  // Advance one clock edge and apply the model's view of that edge.
  task automatic tick();
    bit pass;
    pass = model_pass(Cond, m_flags);
    @(posedge clk);
    #1;
    if (!reset) begin
      m_flags = 4'h0; m_condexd = 1'b0; m_annul = 0;
    end else begin
      if (FlagW[1] && pass) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && pass) m_flags[1:0] = ALUFlags[1:0];
      if ((RegW || PCS || MemW) && !m_condexd && m_annul < 65535) m_annul++;
      m_condexd = pass;
    end
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    // While held in reset, writes stay gated and only NextPC reaches the PC.
    settle();
    check("rst_regwrite", 32'(RegWrite), 32'h0);
    check("rst_memwrite", 32'(MemWrite), 32'h0);
    check("rst_pcwrite",  32'(PCWrite),  32'h1);
    check("rst_annul",    32'(AnnulCount), 32'h0);
    tick();
  endtask

  initial begin
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    m_flags = 4'h0; m_condexd = 1'b0; m_annul = 0;

    do_reset();
    $display("reset: Flags=%0h CondExD=%0b AnnulCount=%0h", Flags, CondExD, AnnulCount);

    // AL with full flag write, then a gated register write that passes.
    drive(1'b1, 4'hE, 4'hA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); settle();
    check("al_flags",    32'(Flags),    32'hA);
    check("al_regwrite", 32'(RegWrite), 32'h1);
    tick();
    $display("al flag load: Flags=%0h RegWrite=%0b", Flags, RegWrite);

    // NE with Z set: the commit is annulled and counted.
    do_reset();
    drive(1'b1, 4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); settle();
    check("ne_regwrite", 32'(RegWrite), 32'h0);
    check("ne_memwrite", 32'(MemWrite), 32'h0);
    check("ne_annul0",   32'(AnnulCount), 32'h0);
    tick();
    drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("ne_annul1", 32'(AnnulCount), 32'h1);
    tick();
    $display("ne annul: AnnulCount=%0h", AnnulCount);

    // Only the N,Z group is written.
    do_reset();
    drive(1'b1, 4'hE, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    settle();
    check("nz_only_flags", 32'(Flags), 32'hC);
    tick();
    $display("nz group write: Flags=%0h", Flags);

    // NextPC is ungated; PCS is gated by the pass bit.
    do_reset();
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); settle();
    check("nextpc_pcwrite", 32'(PCWrite), 32'h1);
    tick();
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0); settle();
    check("pcs_gated_pcwrite", 32'(PCWrite), 32'h0);
    tick();
    $display("pc gating: PCWrite=%0b", PCWrite);

    // Every condition code against every flag value.
    do_reset();
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, 4'(c), 4'(~f), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
      end
    end
    drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    $display("cond sweep done: checks=%0d", checks);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 39) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cyc();
    end
    $display("random traffic done: checks=%0d", checks);

    // Saturation of the annul counter.
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
    end
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("annul_fffe", 32'(AnnulCount), 32'hFFFE);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    end
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("annul_sat", 32'(AnnulCount), 32'hFFFF);
    tick();
    drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0); cyc();
    settle();
    check("annul_hold", 32'(AnnulCount), 32'hFFFF);
    tick();
    $display("annul saturation: AnnulCount=%0h", AnnulCount);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/condlogic.md
CONDLOGIC -- requirements
Module: condlogic

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
REQ-003 SHALL have: Cond  input  4  condition field, Instr[31:28].
REQ-004 SHALL have: ALUFlags  input  4  ALU result flags {N,Z,C,V} of the current cycle.
REQ-005 SHALL have: FlagW  input  2  flag-write request from decoder; [1]=N,Z group, [0]=C,V group.
REQ-006 SHALL have: PCS  input  1  PC-source write request (Rd==15 writeback or branch).
REQ-007 SHALL have: NextPC  input  1  unconditional PC increment request (fetch state).
REQ-008 SHALL have: RegW  input  1  register-file write request.
REQ-009 SHALL have: MemW  input  1  data-memory write request.
REQ-010 SHALL have: PCWrite  output  1  gated PC write enable.
REQ-011 SHALL have: RegWrite  output  1  gated register-file write enable.
REQ-012 SHALL have: MemWrite  output  1  gated memory write enable.
REQ-013 SHALL have: Flags  output  4  architectural flag register {N,Z,C,V}.
REQ-014 SHALL have: CondExD  output  1  registered condition-pass bit.
REQ-015 SHALL have: AnnulCount  output  16  saturating count of annulled instruction commits.

Function
REQ-016 SHALL compute combinational CondEx from Cond and the registered Flags (not ALUFlags) per: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 -> 0 (reserved, annul).
REQ-017 SHALL form FlagWrite[1:0] = FlagW & {CondEx,CondEx}, combinational, same cycle.
REQ-018 SHALL load Flags[3:2] <= ALUFlags[3:2] on a clock edge with FlagWrite[1]=1, else hold.
REQ-019 SHALL load Flags[1:0] <= ALUFlags[1:0] on a clock edge with FlagWrite[0]=1, else hold; the two groups update independently.
REQ-020 SHALL register CondExD <= CondEx on every non-reset clock edge (one-cycle delay, no enable).
REQ-021 SHALL drive RegWrite = RegW & CondExD and MemWrite = MemW & CondExD, combinational.
REQ-022 SHALL drive PCWrite = (PCS & CondExD) | NextPC; NextPC is never gated by condition.
REQ-023 SHALL define a commit request as (RegW | PCS | MemW) = 1 in a cycle; simultaneous RegW and PCS count as one commit.
REQ-024 SHALL increment AnnulCount by 1 on a clock edge where a commit request is present and CondExD=0.
REQ-025 SHALL saturate AnnulCount at 16'hFFFF; no wrap to 0.
REQ-026 SHALL not change AnnulCount when CondExD=1 or when no commit request is present.
REQ-027 SHALL use the Flags value held before the edge for CondEx; a same-cycle flag update affects CondEx only from the next cycle.

Reset
REQ-028 SHALL, on a clock edge with reset=0, set Flags=4'b0000, CondExD=0, AnnulCount=16'h0000, overriding all other updates.
REQ-029 SHALL, while reset=0, still drive the combinational outputs from inputs and reset state (PCWrite = NextPC, RegWrite=0, MemWrite=0 after the first reset edge).
REQ-030 SHALL, on reset asserted mid-instruction, discard the pending CondExD so that no gated write issues on the cycle after reset release unless CondEx=1 on the release cycle.

Verification
REQ-031 SHALL cover: after reset, Cond=1110, FlagW=11, ALUFlags=1010 -> next cycle Flags=1010; following cycle RegW=1 -> RegWrite=1.
REQ-032 SHALL cover: Flags=0100 (Z=1), Cond=0001 (NE), RegW=1 on the next cycle -> RegWrite=0, MemWrite=0, AnnulCount increments 0->1.
REQ-033 SHALL cover: FlagW=10 with ALUFlags=1111 from Flags=0000 under AL -> Flags=1100 (C,V unchanged).
REQ-034 SHALL cover: NextPC=1 with CondExD=0 -> PCWrite=1; PCS=1 with CondExD=0, NextPC=0 -> PCWrite=0.
REQ-035 SHALL cover: AnnulCount preloaded to FFFE by 65534 annulled commits, then 3 more annulled commits -> AnnulCount=FFFF and holds.
REQ-036 SHALL cover: sweep all 16 Cond codes against all 16 Flags values -> CondExD matches the REQ-016 table one cycle later.
